// File: rtl/nibble_serial_alu.sv
// Digit-serial add/subtract with optional BCD adjust, one nibble per clock, LSB first.
// Start-to-done latency is NIBBLES cycles; start is ignored while busy and accepted again in the done cycle.
module nibble_serial_alu #(
   parameter int NIBBLES    = 4,
   parameter bit DECIMAL_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic                 decimal,
   input  logic                 carry_in,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] result,
   output logic                 carry_out,
   output logic                 zero
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic            r_sub;
   logic            r_dec;
   logic            r_c;
   logic [IW-1:0]   r_idx;
   logic [W-1:0]    r_result;
   logic            r_carry;
   logic            r_zero;
   logic            r_busy;
   logic            r_done;

   logic [IW+1:0]   w_bitpos;
   logic [3:0]      w_a_nib;
   logic [3:0]      w_b_nib;
   logic [4:0]      w_sum;
   logic [4:0]      w_diff;
   logic [3:0]      w_digit;
   logic            w_c_next;
   logic [W-1:0]    w_res_next;

   always_comb begin
      w_bitpos = {r_idx, 2'b00};
      w_a_nib  = 4'(r_a >> w_bitpos);
      w_b_nib  = 4'(r_b >> w_bitpos);
      w_sum    = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_c};
      w_diff   = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'b0000, r_c};
      w_digit  = w_sum[3:0];
      w_c_next = w_sum[4];
      if (r_sub) begin
         // Bit 4 of the 5-bit difference is the borrow; decimal mode folds 16 down to 10.
         w_c_next = w_diff[4];
         w_digit  = (r_dec && w_diff[4]) ? (w_diff[3:0] - 4'd6) : w_diff[3:0];
      end else if (r_dec && (w_sum >= 5'd10)) begin
         w_c_next = 1'b1;
         w_digit  = w_sum[3:0] + 4'd6;
      end
      w_res_next = r_result;
      w_res_next[w_bitpos +: 4] = w_digit;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_dec    <= 1'b0;
         r_c      <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_sub   <= op[1];
                  r_dec   <= decimal & DECIMAL_EN;
                  // ADC and SBC are the odd opcodes; only they consume carry_in.
                  r_c     <= op[0] & carry_in;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_result <= w_res_next;
               r_c      <= w_c_next;
               r_idx    <= r_idx + 1'b1;
               if (r_idx == LAST) begin
                  r_idx   <= '0;
                  r_carry <= w_c_next;
                  r_zero  <= (w_res_next == '0);
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;
   assign carry_out = r_carry;
   assign zero      = r_zero;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Bench for nibble_serial_alu: directed vector table, hand sequences and random ops vs a digit-arithmetic model.
module tb_nibble_serial_alu;

   logic        clk;
   logic        reset_n;

   logic        start, dec, cin, busy, done, cout, zero;
   logic [1:0]  op;
   logic [15:0] a, b, result;

   logic        s1_start, s1_dec, s1_cin, s1_busy, s1_done, s1_cout, s1_zero;
   logic [1:0]  s1_op;
   logic [3:0]  s1_a, s1_b, s1_result;

   int checks = 0;
   int errors = 0;

   nibble_serial_alu #(.NIBBLES(4), .DECIMAL_EN(1'b1)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .decimal(dec),
      .carry_in(cin), .a(a), .b(b), .busy(busy), .done(done),
      .result(result), .carry_out(cout), .zero(zero)
   );

   nibble_serial_alu #(.NIBBLES(1), .DECIMAL_EN(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(s1_start), .op(s1_op), .decimal(s1_dec),
      .carry_in(s1_cin), .a(s1_a), .b(s1_b), .busy(s1_busy), .done(s1_done),
      .result(s1_result), .carry_out(s1_cout), .zero(s1_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic        dec;
      logic        ci;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        c;
      logic        z;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: digit-by-digit school arithmetic on integers.
   task automatic model(input int n, input logic [1:0] o, input logic d, input logic ci,
                        input logic [31:0] aa, input logic [31:0] bb,
                        output logic [31:0] res, output logic co, output logic z);
      int c, da, db, s, dig;
      res = 0;
      c = (o == 2'd1 || o == 2'd3) ? int'(ci) : 0;
      for (int i = 0; i < n; i++) begin
         da = int'((aa >> (4 * i)) & 32'hF);
         db = int'((bb >> (4 * i)) & 32'hF);
         if (o < 2'd2) begin
            s = da + db + c;
            if (d && s >= 10) begin dig = (s + 6) % 16; c = 1; end
            else begin dig = s % 16; c = s / 16; end
         end else begin
            s = da - db - c;
            c = (s < 0) ? 1 : 0;
            dig = (d && s < 0) ? ((s - 6) & 15) : (s & 15);
         end
         res = res | (32'(dig) << (4 * i));
      end
      co = c[0];
      z  = (res == 0);
   endtask

   // Called #1 after an edge with the DUT idle or in its done cycle.
   task automatic run4(input logic [1:0] o, input logic d, input logic ci,
                       input logic [15:0] aa, input logic [15:0] bb);
      int cnt;
      op = o; dec = d; cin = ci; a = aa; b = bb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      while (!done && cnt < 20) begin
         chk("busy_during_run", busy, 1);
         @(posedge clk); #1;
         cnt++;
      end
      chk("latency4", cnt, 4);
      chk("busy_at_done", busy, 0);
   endtask

   task automatic run1(input logic [1:0] o, input logic d, input logic ci,
                       input logic [3:0] aa, input logic [3:0] bb);
      int cnt;
      s1_op = o; s1_dec = d; s1_cin = ci; s1_a = aa; s1_b = bb; s1_start = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0;
      cnt = 0;
      while (!s1_done && cnt < 20) begin
         chk("n1_busy_during_run", s1_busy, 1);
         @(posedge clk); #1;
         cnt++;
      end
      chk("latency1", cnt, 1);
   endtask

   task automatic chk_res4(input string tag, input logic [31:0] er, input logic ec, input logic ez);
      chk({tag, "_result"}, result, er);
      chk({tag, "_carry"}, cout, ec);
      chk({tag, "_zero"}, zero, ez);
   endtask

   initial begin
      logic [31:0] er;
      logic        ec, ez;
      int          cnt, seen;

      vt[0] = '{2'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
      vt[1] = '{2'd0, 1'b1, 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b1};
      vt[2] = '{2'd2, 1'b1, 1'b0, 16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0};
      vt[3] = '{2'd3, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
      vt[4] = '{2'd2, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
      vt[5] = '{2'd1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
      vt[6] = '{2'd1, 1'b1, 1'b1, 16'h0999, 16'h0000, 16'h1000, 1'b0, 1'b0};
      vt[7] = '{2'd3, 1'b1, 1'b1, 16'h1000, 16'h0001, 16'h0998, 1'b0, 1'b0};
      vt[8] = '{2'd0, 1'b1, 1'b0, 16'h000A, 16'h0000, 16'h0010, 1'b0, 1'b0};
      vt[9] = '{2'd0, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

      reset_n = 1'b0;
      start = 0; op = 0; dec = 0; cin = 0; a = 0; b = 0;
      s1_start = 0; s1_op = 0; s1_dec = 0; s1_cin = 0; s1_a = 0; s1_b = 0;
      #12;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_result", result, 0);
      chk("reset_carry", cout, 0);
      chk("reset_zero", zero, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run4(vt[i].op, vt[i].dec, vt[i].ci, vt[i].a, vt[i].b);
         chk_res4($sformatf("vec%0d", i), 32'(vt[i].res), vt[i].c, vt[i].z);
      end

      // done is one cycle wide and outputs hold afterwards
      run4(2'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("result_holds", result, 16'h2233);

      // start during a run is ignored, then back-to-back launch in the done cycle
      op = 2'd0; dec = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h0FFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      op = 2'd2; dec = 1'b1; a = 16'h5555; b = 16'h1111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 3;
      while (!done && cnt < 20) begin @(posedge clk); #1; cnt++; end
      chk("ignored_start_latency", cnt, 4);
      chk("ignored_start_result", result, 16'h2233);
      run4(2'd0, 1'b0, 1'b0, 16'h0001, 16'h0002);
      chk_res4("back_to_back", 32'h0003, 1'b0, 1'b0);

      // reset in the middle of a run
      run4(2'd3, 1'b0, 1'b1, 16'h0000, 16'h0000);
      chk_res4("pre_reset", 32'hFFFF, 1'b1, 1'b0);
      op = 2'd0; dec = 1'b0; a = 16'h1111; b = 16'h1111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_carry", cout, 0);
      chk("midrst_zero", zero, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("no_done_after_reset", seen, 0);
      chk("idle_after_reset", busy, 0);
      run4(2'd0, 1'b1, 1'b0, 16'h0045, 16'h0055);
      chk_res4("after_reset", 32'h0100, 1'b0, 1'b0);

      // single-nibble instance
      run1(2'd2, 1'b1, 1'b0, 4'h7, 4'h9);
      chk("n1_dec_sub_result", s1_result, 4'h8);
      chk("n1_dec_sub_carry", s1_cout, 1);
      chk("n1_dec_sub_zero", s1_zero, 0);
      run1(2'd2, 1'b0, 1'b0, 4'h7, 4'h9);
      chk("n1_bin_sub_result", s1_result, 4'hE);
      chk("n1_bin_sub_carry", s1_cout, 1);
      for (int i = 0; i < 20; i++) begin
         logic [1:0] ro;
         logic       rd, rc;
         logic [3:0] ra, rb;
         ro = 2'($urandom_range(0, 3)); rd = 1'($urandom); rc = 1'($urandom);
         ra = 4'($urandom); rb = 4'($urandom);
         model(1, ro, rd, rc, 32'(ra), 32'(rb), er, ec, ez);
         run1(ro, rd, rc, ra, rb);
         chk("n1_rand_result", s1_result, er);
         chk("n1_rand_carry", s1_cout, ec);
         chk("n1_rand_zero", s1_zero, ez);
      end

      // random four-nibble operations
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  ro;
         logic        rd, rc;
         logic [15:0] ra, rb;
         ro = 2'($urandom_range(0, 3)); rd = 1'($urandom); rc = 1'($urandom);
         ra = 16'($urandom); rb = 16'($urandom);
         if (i % 5 == 0) rb = ra;
         model(4, ro, rd, rc, 32'(ra), 32'(rb), er, ec, ez);
         run4(ro, rd, rc, ra, rb);
         chk_res4("rand4", er, ec, ez);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_alu.md
Name: nibble_serial_alu

Overview:
Multi-nibble add/subtract unit with E0C6S46-compatible binary and decimal (BCD) adjust. It processes one 4-bit digit per clock, LSB nibble first, and propagates carry/borrow between nibbles. It generalises the core's single-nibble ADD/ADC/SUB/SBC datapath to N-digit operands, for wide arithmetic such as multi-digit counters and timers. It sits beside the CPU core as a start/done coprocessor.

Parameters:
NIBBLES, 4, operand width in 4-bit digits (1..8); all data ports are 4*NIBBLES bits wide.
DECIMAL_EN, 1, 1 = honour the decimal input; 0 = decimal input ignored, unit is binary only.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  launch request; sampled only when busy=0.
op  in  2  operation: 0 ADD, 1 ADC (add with carry_in), 2 SUB, 3 SBC (subtract with carry_in as borrow).
decimal  in  1  BCD adjust enable, latched at start.
carry_in  in  1  carry (ADC) or borrow (SBC) into nibble 0; ignored for ADD and SUB.
a  in  4*NIBBLES  first operand, latched at start.
b  in  4*NIBBLES  second operand, latched at start.
busy  out  1  operation in progress.
done  out  1  single-cycle completion pulse.
result  out  4*NIBBLES  result digits.
carry_out  out  1  final carry (add) or borrow (sub).
zero  out  1  1 when all result nibbles are 0.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; busy=0, done=0, result=0, carry_out=0, zero=0; nibble index=0.
- Reset mid-operation: operation is abandoned, all outputs take reset values, and no done pulse is produced.
- States:
  - IDLE: start=1 at edge k latches a, b, op, decimal (ANDed with DECIMAL_EN) and initial carry c0. c0 = carry_in for ADC/SBC, 0 otherwise. Transition to RUN; busy=1 after edge k; done=0.
  - RUN: at edge k+1+i, nibble i (i=0..NIBBLES-1) is computed from the latched a[i], b[i] and the running carry c. The digit is written into result[4i+3:4i] and c is updated.
  - After the edge for i=NIBBLES-1 (edge k+NIBBLES): state returns to IDLE; busy=0; done=1 for exactly one cycle; carry_out=c; zero=(full result==0).
- Latency: start to done is exactly NIBBLES cycles. Back-to-back operation is allowed: start sampled high while done=1 launches immediately.
- start while busy=1 is ignored; latched operands are unaffected.
- Add nibble (ADD/ADC):
  - s = a+b+c as a 5-bit value.
  - If decimal and s>=10: digit=(s+6)[3:0], c=1.
  - Otherwise: {c,digit}=s.
- Sub nibble (SUB/SBC):
  - d = a-b-c as a 5-bit two's-complement value; borrow = d[4].
  - If decimal and borrow: digit=(d-6)[3:0].
  - Otherwise: digit=d[3:0].
  - c=borrow in both cases.
- Non-BCD digits (A-F) in decimal mode are not rejected; they are processed by the same formulas.
- During RUN: result nibbles above i retain prior contents, and carry_out/zero hold their previous values.
- Outputs hold until the next completion or reset.

Test Plan:
- NIBBLES=1, decimal=1, SUB, a=7, b=9 -> done 1 cycle after start; result=8, carry_out=1, zero=0. Same stimulus with decimal=0 -> result=E, carry_out=1.
- NIBBLES=4, binary ADD, a=0x1234, b=0x0FFF -> result=0x2233, carry_out=0, zero=0, done exactly 4 cycles after start; busy high for those 4 cycles.
- NIBBLES=4, decimal ADD, a=0x9999, b=0x0001 -> result=0x0000, carry_out=1, zero=1. Decimal SUB, a=0x0100, b=0x0001 -> result=0x0099, carry_out=0.
- NIBBLES=4, binary SBC, a=0, b=0, carry_in=1 -> result=0xFFFF, carry_out=1. The same with op=SUB -> result=0, carry_out=0, zero=1 (carry_in ignored).
- Pulse start again 2 cycles into a run with different operands -> ignored; original result is produced. Then assert start in the done cycle -> second operation completes 4 cycles later.
- Deassert reset_n 2 cycles into a run -> busy, done, result, carry_out and zero go to 0 immediately. After release: no done pulse; IDLE accepts a new start.
